// File: rtl/sum_chain_pkg.sv
// Shared types and defaults for the registered operand sum chain.
// The stage record is reused for all three pipeline stage registers.
package sum_chain_pkg;

    localparam int SUM_WIDTH_DEF = 16;
    localparam int FORCE_VAL_DEF = 5;

    // Fields are sized for the default width; narrower builds zero-extend into them.
    typedef struct packed {
        logic                     valid;
        logic                     forced;
        logic [SUM_WIDTH_DEF-1:0] a;
        logic [SUM_WIDTH_DEF-1:0] b;
        logic [SUM_WIDTH_DEF-1:0] c;
        logic [SUM_WIDTH_DEF-1:0] d;
        logic [SUM_WIDTH_DEF-1:0] f;
        logic [SUM_WIDTH_DEF-1:0] e;
    } stage_t;

endpackage

// File: rtl/sum_chain_add.sv
// Two-input WIDTH-bit adder: modulo wrap by default, saturating to all-ones
// when SUM_CHAIN_SAT_EN is defined.
import sum_chain_pkg::*;

module sum_chain_add #(
    parameter int WIDTH = SUM_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};

`ifdef SUM_CHAIN_SAT_EN
    assign sum = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
    logic unused_carry;
    assign unused_carry = raw[WIDTH];
    assign sum          = raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/sum_chain_pipe.sv
// Three-stage valid/ready pipeline computing c=a+b, d=(a+b)+c, f=c+d, e=forced?0:f.
// Adders saturate instead of wrapping when SUM_CHAIN_SAT_EN is defined.
import sum_chain_pkg::*;

module sum_chain_pipe #(
    parameter int WIDTH     = SUM_WIDTH_DEF,
    parameter int FORCE_VAL = FORCE_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] out_e,
    output logic             out_forced,
    output logic [15:0]      out_cnt
);

    localparam int SW = SUM_WIDTH_DEF;

    // Handshake: a transfer happens on a rising edge where valid && ready; valid
    // never waits on ready, and a stage that is stalled holds every register.
    stage_t s1, s2, s3;
    stage_t s1_next, s2_next, s3_next;

    logic s1_load, s2_load, s3_load;
    logic s1_drain, s2_drain, s3_drain;

    logic [WIDTH-1:0] s1_sum, s2_ab, s2_d, s3_f;

    sum_chain_add #(.WIDTH(WIDTH)) u_add_ab  (.a(in_a),            .b(in_b),            .sum(s1_sum));
    sum_chain_add #(.WIDTH(WIDTH)) u_add_ab2 (.a(s1.a[WIDTH-1:0]), .b(s1.b[WIDTH-1:0]), .sum(s2_ab));
    sum_chain_add #(.WIDTH(WIDTH)) u_add_d   (.a(s2_ab),           .b(s1.c[WIDTH-1:0]), .sum(s2_d));
    sum_chain_add #(.WIDTH(WIDTH)) u_add_f   (.a(s2.c[WIDTH-1:0]), .b(s2.d[WIDTH-1:0]), .sum(s3_f));

    // Ready ripples back from out_ready so bubbles collapse and full flow needs no slack.
    always_comb begin
        s3_drain = s3.valid && out_ready;
        s3_load  = s2.valid && (!s3.valid || s3_drain);
        s2_drain = s3_load;
        s2_load  = s1.valid && (!s2.valid || s2_drain);
        s1_drain = s2_load;
        in_ready = !s1.valid || s1_drain;
        s1_load  = in_valid && in_ready;
    end

    always_comb begin
        s1_next        = '0;
        s1_next.valid  = 1'b1;
        s1_next.forced = (in_a == WIDTH'(FORCE_VAL));
        s1_next.a      = SW'(in_a);
        s1_next.b      = SW'(in_b);
        s1_next.c      = SW'(s1_sum);

        s2_next        = '0;
        s2_next.valid  = 1'b1;
        s2_next.forced = s1.forced;
        s2_next.c      = s1.c;
        s2_next.d      = SW'(s2_d);

        s3_next        = '0;
        s3_next.valid  = 1'b1;
        s3_next.forced = s2.forced;
        s3_next.c      = s2.c;
        s3_next.d      = s2.d;
        s3_next.f      = SW'(s3_f);
        s3_next.e      = s2.forced ? '0 : SW'(s3_f);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            out_cnt <= '0;
        end else begin
            if (s1_load)       s1       <= s1_next;
            else if (s1_drain) s1.valid <= 1'b0;

            if (s2_load)       s2       <= s2_next;
            else if (s2_drain) s2.valid <= 1'b0;

            if (s3_load)       s3       <= s3_next;
            else if (s3_drain) s3.valid <= 1'b0;

            if (s3_drain) out_cnt <= out_cnt + 16'd1;
        end
    end

    assign out_valid  = s3.valid;
    assign out_c      = s3.c[WIDTH-1:0];
    assign out_d      = s3.d[WIDTH-1:0];
    assign out_f      = s3.f[WIDTH-1:0];
    assign out_e      = s3.e[WIDTH-1:0];
    assign out_forced = s3.forced;

    // Record fields that a given stage never carries stay zero and are not read.
    logic unused_fields;
    assign unused_fields = ^{s1.d, s1.f, s1.e, s2.a, s2.b, s2.f, s2.e, s3.a, s3.b};

endmodule

// File: tb/tb_sum_chain_pipe.sv
// Self-checking bench for sum_chain_pipe: vector table, back-pressure, random
// handshake traffic and mid-stream reset, checked through an expected queue.
import sum_chain_pkg::*;

module tb_sum_chain_pipe;

    localparam int W  = 16;
    localparam int RW = 4*W + 1;

    typedef struct {
        logic [W-1:0] a, b, c, d, f, e;
        logic         forced;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_c, out_d, out_f, out_e;
    logic         out_forced;
    logic [15:0]  out_cnt;

    logic rand_rdy    = 1'b0;
    logic rand_bit    = 1'b1;
    logic ready_force = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_acc = -1;
    int first_out = -1;
    int last_out  = -1;
    logic lat_arm = 1'b0;

    logic [RW-1:0] exp_q[$];
    logic [15:0]   exp_cnt = '0;
    vec_t          tbl[12];

    sum_chain_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_d(out_d), .out_f(out_f), .out_e(out_e),
        .out_forced(out_forced), .out_cnt(out_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        rand_bit = ($urandom_range(0, 3) != 0);
    end
    assign out_ready = rand_rdy ? rand_bit : ready_force;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] madd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
`ifdef SUM_CHAIN_SAT_EN
        return s[W] ? {W{1'b1}} : s[W-1:0];
`else
        return s[W-1:0];
`endif
    endfunction

    function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] c, d, f, e;
        logic         fr;
        c  = madd(a, b);
        d  = madd(madd(a, b), c);
        f  = madd(c, d);
        fr = (a == W'(FORCE_VAL_DEF));
        e  = fr ? '0 : f;
        return {c, d, f, e, fr};
    endfunction

    function automatic logic [RW-1:0] pack_vec(input vec_t v);
        return {v.c, v.d, v.f, v.e, v.forced};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_accept(input logic [RW-1:0] exp);
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                if (lat_arm && first_acc < 0) first_acc = cyc;
                done = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    check("accept_timeout", RW'(n), '0);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [RW-1:0] exp);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        wait_accept(exp);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", RW'(exp_q.size()), '0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [RW-1:0] e_v;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", RW'(out_valid), '0);
            end else begin
                e_v = exp_q.pop_front();
                check("result", {out_c, out_d, out_f, out_e, out_forced}, e_v);
            end
            check("out_cnt_live", RW'(out_cnt), RW'(exp_cnt));
            exp_cnt++;
            if (lat_arm) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0]  ra, rb;
        logic [RW-1:0] snap;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;

        for (int i = 0; i < 10; i++) begin
            int v;
            v = i + 2;
            tbl[i].a = W'(v);      tbl[i].b = W'(v);
            tbl[i].c = W'(2 * v);  tbl[i].d = W'(4 * v);  tbl[i].f = W'(6 * v);
            tbl[i].forced = (v == 5);
            tbl[i].e = (v == 5) ? '0 : W'(6 * v);
        end
        tbl[10].a = 16'hFFFF; tbl[10].b = 16'h0001; tbl[10].forced = 1'b0;
        tbl[11].a = 16'h0005; tbl[11].b = 16'hFFFB; tbl[11].forced = 1'b1;
`ifdef SUM_CHAIN_SAT_EN
        tbl[10].c = 16'hFFFF; tbl[10].d = 16'hFFFF; tbl[10].f = 16'hFFFF; tbl[10].e = 16'hFFFF;
        tbl[11].c = 16'hFFFF; tbl[11].d = 16'hFFFF; tbl[11].f = 16'hFFFF; tbl[11].e = 16'h0000;
`else
        tbl[10].c = 16'h0000; tbl[10].d = 16'h0000; tbl[10].f = 16'h0000; tbl[10].e = 16'h0000;
        tbl[11].c = 16'h0000; tbl[11].d = 16'h0000; tbl[11].f = 16'h0000; tbl[11].e = 16'h0000;
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", RW'(out_valid), '0);
        check("rst_in_ready", RW'(in_ready), RW'(1));
        check("rst_data", {out_c, out_d, out_f, out_e, out_forced}, '0);
        check("rst_cnt", RW'(out_cnt), '0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out_valid", RW'(out_valid), '0);
        end
        @(posedge clk);
        #1;

        // streaming vector table
        ready_force = 1'b1;
        lat_arm     = 1'b1;
        for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, pack_vec(tbl[i]));
        in_valid = 1'b0;
        drain();
        lat_arm = 1'b0;
        check("latency", RW'(first_out - first_acc), RW'(3));
        check("throughput", RW'(last_out - first_out), RW'(9));
        check("cnt_after_stream", RW'(out_cnt), RW'(10));

        // wrap / saturation and forced-with-zero corners
        for (int i = 10; i < 12; i++) send(tbl[i].a, tbl[i].b, pack_vec(tbl[i]));
        in_valid = 1'b0;
        drain();

        // full back-pressure: 3 fill the pipe, 4th waits
        ready_force = 1'b0;
        for (int k = 0; k < 3; k++) send(W'(100 + k), W'(3 * k), model(W'(100 + k), W'(3 * k)));
        in_a = 16'd200; in_b = 16'd7; in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", RW'(in_ready), '0);
        snap = {out_c, out_d, out_f, out_e, out_forced};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_valid_held", RW'(out_valid), RW'(1));
            check("bp_data_stable", {out_c, out_d, out_f, out_e, out_forced}, snap);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        wait_accept(model(16'd200, 16'd7));
        in_valid = 1'b0;
        drain();
        check("cnt_after_bp", RW'(out_cnt), RW'(16));

        // random handshake traffic
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            ra = ($urandom_range(0, 7) == 0) ? W'(FORCE_VAL_DEF) : W'($urandom_range(0, 16'hFFFF));
            rb = W'($urandom_range(0, 16'hFFFF));
            send(ra, rb, model(ra, rb));
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        drain();
        check("cnt_after_random", RW'(out_cnt), RW'(16'(1016)));

        // reset with pairs in flight
        ready_force = 1'b0;
        send(16'd7, 16'd8, model(16'd7, 16'd8));
        send(16'd9, 16'd1, model(16'd9, 16'd1));
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_valid", RW'(out_valid), RW'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", RW'(out_valid), '0);
        check("mid_rst_cnt", RW'(out_cnt), '0);
        check("mid_rst_in_ready", RW'(in_ready), RW'(1));
        exp_q.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_force = 1'b1;
        send(16'd20, 16'd30, model(16'd20, 16'd30));
        send(16'd40, 16'd50, model(16'd40, 16'd50));
        in_valid = 1'b0;
        drain();
        check("cnt_after_rst", RW'(out_cnt), RW'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_chain_pipe.md
# sum_chain_pipe

Registered, handshaked implementation of the operand sum chain: for each accepted operand pair (a, b) it produces c = a+b, d = a+b+c, f = c+d and a conditionally zeroed copy e of f. It sits directly downstream of the operand sequencer that steps a/b, and it replaces the combinational `always @*` chain with a 3-stage pipeline. Its outputs feed the display/check stage.

## Interface
Parameters:
- WIDTH, 16, operand and result width.
- FORCE_VAL, 5, when stage-1 operand a equals this value, e is forced to 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low. Deassertion is synchronised externally.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept the pair this cycle.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_c, out_d, out_f, out_e  out  WIDTH each  chain results.
- out_forced  out  1  e was forced to 0 for this result.
- out_cnt  out  16  number of results delivered; wraps at 2^16.

## Operation
- The input transfers when in_valid && in_ready. The output transfers when out_valid && out_ready.
- Stage S1 registers a, b and c = a+b. It also registers forced = (a == FORCE_VAL).
- Stage S2 registers c, forced and d = a+b+c, evaluated as (a+b) + c through two chained adders.
- Stage S3 registers c, d, f = c+d, e = forced ? 0 : f, and forced.
- Each stage has a valid bit. Stage k loads when stage k-1 is valid and stage k is empty or draining this cycle.
- A stage that does not load but drains clears its valid bit.
- in_ready = !s1_valid || s1 draining. It depends combinationally on out_ready through the stage chain; no other combinational path runs from input to output.
- A stalled stage holds all of its registers unchanged.
- Arithmetic is modulo 2^WIDTH: carries are discarded (see Configuration).
- out_cnt increments by 1 on each output transfer and wraps from 16'hFFFF to 0.
- Outputs are stage-3 registers driven directly; there is no output logic.
- Reset values: all stage valid bits = 0, out_valid = 0, in_ready = 1, all data outputs = 0, out_forced = 0, out_cnt = 0.
- Reset mid-operation: in-flight pairs are discarded and no partial result is emitted. After release the block behaves as after power-up.

## Timing
- Latency: a pair accepted in cycle N appears on out_valid in cycle N+3 when there is no stall.
- Throughput: one result per cycle while out_ready is held at 1.
- Full back-pressure: the pipeline holds 3 results, and in_ready drops the cycle after the third pair is accepted with out_ready = 0.
- Bubbles collapse. A stalled S3 with empty S1/S2 still accepts input until those stages are full.
- Simultaneous accept and output transfer in the same cycle is legal and loses no data.
- out_valid and the output data stay stable while out_ready = 0.
- Arithmetic corner cases:
  - a = FORCE_VAL with f = 0 still sets out_forced = 1.
  - WIDTH'hFFFF + 1 wraps to 0.

## Configuration
- SUM_CHAIN_SAT_EN defined: every adder saturates. Any carry out of the MSB yields all-ones ({WIDTH{1'b1}}), and saturation propagates down the chain.
- SUM_CHAIN_SAT_EN undefined: plain modulo-2^WIDTH wrap.
- Handshake, latency and the forced-zero rule are identical in both builds.

## Structure
- Package sum_chain_pkg holds:
  - SUM_WIDTH_DEF = 16 and FORCE_VAL_DEF = 5;
  - typedef stage_t, a packed struct {valid, forced, a, b, c, d, f, e}, used for all three stage registers.
- Sub-module sum_chain_add: a WIDTH-bit two-input adder with wrap or saturate selected by SUM_CHAIN_SAT_EN. The block instantiates it four times: a+b, +c, c+d, and the out_cnt path is excluded.

## Test plan
- Reset then idle: all outputs are 0, in_ready = 1, and out_valid stays 0 for 10 cycles.
- Stream a = b = 2..11 with out_ready = 1:
  - out_f = 12, 18, ..., 66 and out_e = out_f, except the a = b = 5 result (c = 10, d = 20, f = 30), which gives e = 0 with out_forced = 1;
  - first result arrives 3 cycles after the first accept, then one per cycle;
  - out_cnt = 10 at the end.
- Back-pressure:
  - hold out_ready = 0 while streaming 4 pairs: in_ready = 0 after 3 accepts and the outputs stay stable;
  - release: all 4 results arrive in order with no loss or duplication.
- Random out_ready/in_valid toggling, 1000 pairs: results match a reference model in order.
- Wrap build, a = 16'hFFFF, b = 1: c = 0, d = 0, f = 0, e = 0, out_forced = 0.
  - With SUM_CHAIN_SAT_EN: c = d = f = e = 16'hFFFF.
- Assert rst_n mid-stream with 2 pairs in flight: out_valid drops to 0 immediately, and after release only new pairs appear. out_cnt restarts at 0.
